// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination-lock controller.
// - lock_state_e: controller states; the encoding is also the display code on state_o.
// - digit_width(): bits needed for one keypad digit (at least 1).
// - max3(): largest of three cycle counts, used to size the shared timer.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROG     = 3'd3,
        ST_LOCKOUT  = 3'd4
    } lock_state_e;

    localparam logic [3:0] FAIL_SAT = 4'd15;

    function automatic int digit_width(input int num_btn);
        return (num_btn <= 2) ? 1 : $clog2(num_btn);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry timeout, lockout and auto-relock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with load_val (wins over counting)
//   load_val   : reload value; expiry is seen load_val+1 cycles after the load
//   expired    : counter has reached zero (held there until the next load)
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: N-button keypad, programmable code, inter-key
// timeout, failed-attempt counting with timed lockout, and auto-relock.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_pulse    : one-cycle press pulses, one bit per button
//   prog_en      : level, requests code programming while unlocked
//   unlocked     : lock open
//   lockout      : lockout active, presses ignored
//   prog_active  : programming in progress
//   state_o      : display code of the current state (see lock_state_e)
//   digit_cnt    : digits entered so far in the current entry/programming
//   fail_cnt     : consecutive failed attempts (saturates at 15)
//   ok_pulse     : one cycle on correct code or committed programming
//   err_pulse    : one cycle on a failed attempt
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [CODE_LEN*digit_width(NUM_BTN)-1:0] DEFAULT_CODE = 8'hE4,
    parameter int MAX_FAIL    = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCKOUT_CYC = 5000,
    parameter int UNLOCK_CYC  = 10000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_BTN-1:0]              btn_pulse,
    input  logic                            prog_en,
    output logic                            unlocked,
    output logic                            lockout,
    output logic                            prog_active,
    output logic [2:0]                      state_o,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
    output logic [3:0]                      fail_cnt,
    output logic                            ok_pulse,
    output logic                            err_pulse
);

    localparam int W      = digit_width(NUM_BTN);
    localparam int CW     = $clog2(CODE_LEN + 1);
    localparam int CODE_W = CODE_LEN * W;
    localparam int TW     = $clog2(max3(TIMEOUT_CYC, LOCKOUT_CYC, UNLOCK_CYC)) + 1;

    lock_state_e       state_reg, state_next;
    logic [CW-1:0]     digit_cnt_reg, digit_cnt_next;
    logic [3:0]        fail_reg, fail_next, fail_inc;
    logic              mism_reg, mism_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] shadow_reg, shadow_next;
    logic              ok_reg, ok_next;
    logic              err_reg, err_next;
    logic              unlocked_reg, lockout_reg, prog_reg;

    logic              any_press, valid_press, digit_mismatch, last_digit, entry_bad;
    logic [W-1:0]      press_digit;
    logic              press_reload, timer_load, timer_expired;
    logic [TW-1:0]     timer_val;

    // Press decode: index of the set bit; only meaningful when exactly one bit is set.
    always_comb begin
        press_digit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_pulse[i]) begin
                press_digit = W'(i);
            end
        end
    end

    assign any_press   = |btn_pulse;
    assign valid_press = $onehot(btn_pulse);
    assign last_digit  = (digit_cnt_reg == CW'(CODE_LEN - 1));
    // Incremental comparison against the code digit at the current position;
    // a multi-button press always counts as a mismatch.
    assign digit_mismatch = !valid_press ||
                            (press_digit != code_reg[int'(digit_cnt_reg)*W +: W]);
    assign entry_bad = ((state_reg == ST_ENTRY) && mism_reg) || digit_mismatch;
    assign fail_inc  = (fail_reg == FAIL_SAT) ? fail_reg : fail_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        digit_cnt_next = digit_cnt_reg;
        fail_next      = fail_reg;
        mism_next      = mism_reg;
        code_next      = code_reg;
        shadow_next    = shadow_reg;
        ok_next        = 1'b0;
        err_next       = 1'b0;
        press_reload   = 1'b0;

        case (state_reg)
            ST_LOCKED, ST_ENTRY: begin
                if (any_press) begin
                    press_reload = 1'b1;
                    if (last_digit) begin
                        digit_cnt_next = '0;
                        mism_next      = 1'b0;
                        if (!entry_bad) begin
                            state_next = ST_UNLOCKED;
                            ok_next    = 1'b1;
                            fail_next  = '0;
                        end else begin
                            err_next   = 1'b1;
                            fail_next  = fail_inc;
                            state_next = (fail_inc >= 4'(MAX_FAIL)) ? ST_LOCKOUT : ST_LOCKED;
                        end
                    end else begin
                        state_next     = ST_ENTRY;
                        digit_cnt_next = digit_cnt_reg + CW'(1);
                        mism_next      = entry_bad;
                    end
                end else if (state_reg == ST_ENTRY && timer_expired) begin
                    // Abandoned entry: not counted as a failure.
                    state_next     = ST_LOCKED;
                    digit_cnt_next = '0;
                    mism_next      = 1'b0;
                end
            end

            ST_UNLOCKED: begin
                if (any_press && !prog_en) begin
                    state_next = ST_LOCKED;
                end else if (prog_en) begin
                    state_next     = ST_PROG;
                    digit_cnt_next = '0;
                end else if (timer_expired) begin
                    state_next = ST_LOCKED;
                end
            end

            ST_PROG: begin
                if (!prog_en) begin
                    state_next     = ST_UNLOCKED;
                    digit_cnt_next = '0;
                end else if (valid_press) begin
                    press_reload = 1'b1;
                    shadow_next[int'(digit_cnt_reg)*W +: W] = press_digit;
                    if (last_digit) begin
                        code_next      = shadow_next;
                        ok_next        = 1'b1;
                        state_next     = ST_UNLOCKED;
                        digit_cnt_next = '0;
                    end else begin
                        digit_cnt_next = digit_cnt_reg + CW'(1);
                    end
                end else if (timer_expired) begin
                    state_next     = ST_UNLOCKED;
                    digit_cnt_next = '0;
                end
            end

            ST_LOCKOUT: begin
                if (timer_expired) begin
                    state_next = ST_LOCKED;
                    fail_next  = '0;
                end
            end

            default: begin
                state_next     = ST_LOCKED;
                digit_cnt_next = '0;
                mism_next      = 1'b0;
            end
        endcase
    end

    // The timer is reloaded for the state being entered, or re-armed by an accepted press.
    assign timer_load = press_reload || (state_next != state_reg);

    always_comb begin
        case (state_next)
            ST_UNLOCKED: timer_val = TW'(UNLOCK_CYC - 1);
            ST_LOCKOUT:  timer_val = TW'(LOCKOUT_CYC - 1);
            default:     timer_val = TW'(TIMEOUT_CYC - 1);
        endcase
    end

    lock_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_LOCKED;
            digit_cnt_reg <= '0;
            fail_reg      <= '0;
            mism_reg      <= 1'b0;
            code_reg      <= DEFAULT_CODE;
            shadow_reg    <= '0;
            ok_reg        <= 1'b0;
            err_reg       <= 1'b0;
            unlocked_reg  <= 1'b0;
            lockout_reg   <= 1'b0;
            prog_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_cnt_reg <= digit_cnt_next;
            fail_reg      <= fail_next;
            mism_reg      <= mism_next;
            code_reg      <= code_next;
            shadow_reg    <= shadow_next;
            ok_reg        <= ok_next;
            err_reg       <= err_next;
            unlocked_reg  <= (state_next == ST_UNLOCKED);
            lockout_reg   <= (state_next == ST_LOCKOUT);
            prog_reg      <= (state_next == ST_PROG);
        end
    end

    assign unlocked    = unlocked_reg;
    assign lockout     = lockout_reg;
    assign prog_active = prog_reg;
    assign state_o     = state_reg;
    assign digit_cnt   = digit_cnt_reg;
    assign fail_cnt    = fail_reg;
    assign ok_pulse    = ok_reg;
    assign err_pulse   = err_reg;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: table of vectors, hand-written
// multi-cycle sequences, then randomized presses against a reference model
// that keeps the whole entered sequence and compares it at the end.
module tb_combo_lock_ctrl;

    localparam int LEN  = 4;
    localparam int MAXF = 3;
    localparam int TO   = 20;
    localparam int LO   = 40;
    localparam int UL   = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_pulse;
    logic       prog_en;
    logic       unlocked, lockout, prog_active, ok_pulse, err_pulse;
    logic [2:0] state_o;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;

    int n_checks = 0;
    int n_errors = 0;

    combo_lock_ctrl #(
        .NUM_BTN      (4),
        .CODE_LEN     (LEN),
        .DEFAULT_CODE (8'hE4),
        .MAX_FAIL     (MAXF),
        .TIMEOUT_CYC  (TO),
        .LOCKOUT_CYC  (LO),
        .UNLOCK_CYC   (UL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pulse   (btn_pulse),
        .prog_en     (prog_en),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .prog_active (prog_active),
        .state_o     (state_o),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt),
        .ok_pulse    (ok_pulse),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    logic [14:0] dut_out;
    assign dut_out = {unlocked, lockout, prog_active, state_o, digit_cnt,
                      fail_cnt, ok_pulse, err_pulse};

    // ---------------- reference model ----------------
    // States: 0 locked, 1 entry, 2 unlocked, 3 programming, 4 lockout.
    int m_state;
    int m_code[LEN];
    int m_entry[$];   // digits entered so far, -1 for a multi-button press
    int m_shadow[$];
    int m_fail;
    int m_idle;       // cycles since the timer was last restarted
    bit m_ok, m_err;

    task automatic model_reset();
        m_state = 0;
        m_code  = '{0, 1, 2, 3};
        m_entry.delete();
        m_shadow.delete();
        m_fail = 0;
        m_idle = 0;
        m_ok   = 0;
        m_err  = 0;
    endtask

    task automatic model_finish_entry();
        bit match;
        match = 1;
        for (int i = 0; i < LEN; i++) begin
            if (m_entry[i] != m_code[i]) match = 0;
        end
        m_entry.delete();
        if (match) begin
            m_state = 2;
            m_ok    = 1;
            m_fail  = 0;
        end else begin
            m_err  = 1;
            m_fail = (m_fail < 15) ? m_fail + 1 : 15;
            m_state = (m_fail >= MAXF) ? 4 : 0;
        end
    endtask

    task automatic model_step(input logic [3:0] b, input logic p);
        int  prev, ones, dig;
        bit  press, valid, reload;
        ones   = $countones(b);
        press  = (ones != 0);
        valid  = (ones == 1);
        dig    = -1;
        for (int i = 0; i < 4; i++) if (valid && b[i]) dig = i;
        prev   = m_state;
        reload = 0;
        m_ok   = 0;
        m_err  = 0;
        case (m_state)
            0, 1: begin
                if (press) begin
                    reload = 1;
                    m_entry.push_back(dig);
                    if (m_entry.size() == LEN) model_finish_entry();
                    else m_state = 1;
                end else if (m_state == 1 && m_idle + 1 >= TO) begin
                    m_state = 0;
                    m_entry.delete();
                end
            end
            2: begin
                if (press && !p) m_state = 0;
                else if (p) begin
                    m_state = 3;
                    m_shadow.delete();
                end else if (m_idle + 1 >= UL) m_state = 0;
            end
            3: begin
                if (!p) m_state = 2;
                else if (valid) begin
                    reload = 1;
                    m_shadow.push_back(dig);
                    if (m_shadow.size() == LEN) begin
                        for (int i = 0; i < LEN; i++) m_code[i] = m_shadow[i];
                        m_ok    = 1;
                        m_state = 2;
                    end
                end else if (m_idle + 1 >= TO) m_state = 2;
            end
            default: begin
                if (m_idle + 1 >= LO) begin
                    m_state = 0;
                    m_fail  = 0;
                end
            end
        endcase
        if (m_state != 3) m_shadow.delete();
        if (reload || m_state != prev) m_idle = 0;
        else m_idle++;
    endtask

    function automatic logic [14:0] model_out();
        int dc;
        dc = (m_state == 1) ? m_entry.size() : (m_state == 3) ? m_shadow.size() : 0;
        return {(m_state == 2), (m_state == 4), (m_state == 3), 3'(m_state),
                3'(dc), 4'(m_fail), m_ok, m_err};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One transaction: drive inputs, advance model and DUT one edge, compare.
    task automatic cycle(input logic [3:0] b, input logic p);
        btn_pulse = b;
        prog_en   = p;
        model_step(b, p);
        @(posedge clk);
        #1;
        btn_pulse = '0;
        $display("t=%0t btn=%b prog=%b -> st=%0d dc=%0d fail=%0d ok=%b err=%b ul=%b lo=%b",
                 $time, b, p, state_o, digit_cnt, fail_cnt, ok_pulse, err_pulse,
                 unlocked, lockout);
        chk("model", {1'b0, dut_out}, {1'b0, model_out()});
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d, input logic p);
        cycle(4'(1 << a), p);
        cycle(4'(1 << b), p);
        cycle(4'(1 << c), p);
        cycle(4'(1 << d), p);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] btn;
        logic       prog;
        logic [2:0] st;
        logic       ul;
        logic       ok;
        logic       err;
        logic [3:0] fail;
        logic [2:0] dc;
    } vec_t;

    vec_t vecs[22];

    initial begin
        // btn, prog, expected: state, unlocked, ok, err, fail_cnt, digit_cnt
        vecs[0]  = '{4'b0001, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd1};
        vecs[1]  = '{4'b0010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd2};
        vecs[2]  = '{4'b0100, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd3};
        vecs[3]  = '{4'b1000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0};
        vecs[4]  = '{4'b0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[5]  = '{4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[6]  = '{4'b0010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd1};
        vecs[7]  = '{4'b0010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd2};
        vecs[8]  = '{4'b0100, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd3};
        vecs[9]  = '{4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd1, 3'd0};
        vecs[10] = '{4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0};
        vecs[11] = '{4'b0001, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd1};
        vecs[12] = '{4'b0011, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd2};
        vecs[13] = '{4'b0100, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd3};
        vecs[14] = '{4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd0};
        vecs[15] = '{4'b0001, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2, 3'd1};
        vecs[16] = '{4'b0010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2, 3'd2};
        vecs[17] = '{4'b0100, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2, 3'd3};
        vecs[18] = '{4'b1000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0};
        vecs[19] = '{4'b0000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[20] = '{4'b0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[21] = '{4'b0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0};

        rst_n     = 1'b0;
        btn_pulse = '0;
        prog_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {1'b0, dut_out}, 16'h0000);
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 22; i++) begin
            cycle(vecs[i].btn, vecs[i].prog);
            chk($sformatf("vec%0d", i),
                {3'b0, state_o, unlocked, ok_pulse, err_pulse, fail_cnt, digit_cnt},
                {3'b0, vecs[i].st, vecs[i].ul, vecs[i].ok, vecs[i].err, vecs[i].fail, vecs[i].dc});
        end

        // ---- three failures -> lockout, presses ignored, expiry ----
        cycle(4'b0001, 1'b0);
        chk("relock_state", 16'(state_o), 16'd0);
        for (int f = 0; f < 3; f++) begin
            enter4(1, 1, 2, 3, 1'b0);
            chk($sformatf("fail%0d_err", f), 16'(err_pulse), 16'd1);
            chk($sformatf("fail%0d_cnt", f), 16'(fail_cnt), 16'(f + 1));
        end
        chk("lockout_flag", {lockout, state_o}, {1'b1, 3'd4});
        for (int i = 0; i < 10; i++) cycle(4'(1 << (i % 4)), 1'b0);
        repeat (LO - 11) cycle(4'b0000, 1'b0);
        chk("lockout_hold", 16'(state_o), 16'd4);
        cycle(4'b0000, 1'b0);
        chk("lockout_exit", {state_o, fail_cnt}, {3'd0, 4'd0});

        // ---- inter-key timeout ----
        cycle(4'b0001, 1'b0);
        cycle(4'b0010, 1'b0);
        repeat (TO - 1) cycle(4'b0000, 1'b0);
        chk("timeout_hold", {state_o, digit_cnt}, {3'd1, 3'd2});
        cycle(4'b0000, 1'b0);
        chk("timeout_exit", {state_o, digit_cnt, fail_cnt, err_pulse}, {3'd0, 3'd0, 4'd0, 1'b0});

        // ---- programming a new code ----
        enter4(0, 1, 2, 3, 1'b0);
        chk("unlock_default", 16'(unlocked), 16'd1);
        cycle(4'b0000, 1'b1);
        chk("prog_active", {prog_active, state_o}, {1'b1, 3'd3});
        enter4(3, 3, 0, 1, 1'b1);
        chk("prog_commit", {ok_pulse, state_o}, {1'b1, 3'd2});
        cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        enter4(0, 1, 2, 3, 1'b0);
        chk("old_code_fails", {err_pulse, unlocked}, {1'b1, 1'b0});
        enter4(3, 3, 0, 1, 1'b0);
        chk("new_code_unlocks", {ok_pulse, unlocked, fail_cnt}, {1'b1, 1'b1, 4'd0});

        // ---- multi-button press in a correct entry, then auto-relock ----
        cycle(4'b0001, 1'b0);
        cycle(4'b1000, 1'b0);
        cycle(4'b0011, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0010, 1'b0);
        chk("invalid_press_err", 16'(err_pulse), 16'd1);
        enter4(3, 3, 0, 1, 1'b0);
        repeat (UL - 1) cycle(4'b0000, 1'b0);
        chk("unlock_hold", 16'(unlocked), 16'd1);
        cycle(4'b0000, 1'b0);
        chk("auto_relock", {unlocked, state_o}, {1'b0, 3'd0});

        // ---- reset in the middle of programming ----
        enter4(3, 3, 0, 1, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0001, 1'b1);
        chk("prog_two_digits", 16'(digit_cnt), 16'd2);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {1'b0, dut_out}, 16'h0000);
        prog_en = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        enter4(0, 1, 2, 3, 1'b0);
        chk("default_after_reset", 16'(unlocked), 16'd1);

        // ---- randomized stimulus against the model ----
        begin
            logic rp;
            int   burst;
            rp    = 1'b0;
            burst = 0;
            for (int n = 0; n < 3000; n++) begin
                logic [3:0] b;
                int r, a, c;
                b = 4'b0000;
                if ($urandom_range(0, 99) < 5) rp = ~rp;
                if (burst > 0) begin
                    burst--;
                end else if ($urandom_range(0, 99) < 2) begin
                    burst = $urandom_range(0, 70);
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 45) begin
                        b = 4'b0000;
                    end else if (r < 55) begin
                        a = $urandom_range(0, 3);
                        c = (a + $urandom_range(1, 3)) % 4;
                        b = 4'((1 << a) | (1 << c));
                    end else if (r < 85 && (m_state == 0 || m_state == 1)) begin
                        b = 4'(1 << m_code[m_entry.size()]);
                    end else begin
                        b = 4'(1 << $urandom_range(0, 3));
                    end
                end
                cycle(b, rp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Parametrised combination-lock controller: N-button keypad, programmable code of configurable length, inter-key timeout, failed-attempt counting with timed lockout, and auto-relock.
Consumes single-cycle, already debounced and edge-detected button pulses.
Drives status into the seven-segment display controller and the top-level outputs.
Successor to the fixed 4-button lock FSM.

Parameters:
NUM_BTN, 4, number of keypad buttons (2..16); digit width W = $clog2(NUM_BTN)
CODE_LEN, 4, digits per code (1..8)
DEFAULT_CODE, 8'hE4, reset code, CODE_LEN*W bits; digit i at [i*W +: W], digit 0 entered first (default sequence btn0,btn1,btn2,btn3)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..15)
TIMEOUT_CYC, 1000, idle cycles between presses before an entry is abandoned
LOCKOUT_CYC, 5000, lockout duration in cycles
UNLOCK_CYC, 10000, cycles unlocked before automatic relock

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_pulse  input  NUM_BTN  one-cycle press pulses, one bit per button
prog_en  input  1  level; requests code programming while unlocked
unlocked  output  1  lock open
lockout  output  1  lockout active; all presses ignored
prog_active  output  1  in programming state
state_o  output  3  0=LOCKED 1=ENTRY 2=UNLOCKED 3=PROG 4=LOCKOUT (display encoding)
digit_cnt  output  $clog2(CODE_LEN+1)  digits entered in current entry/programming
fail_cnt  output  4  consecutive failed attempts
ok_pulse  output  1  one cycle on successful code or committed programming
err_pulse  output  1  one cycle on failed attempt

Behaviour:
- Reset (async, rst_n=0): state LOCKED; code register = DEFAULT_CODE; every counter 0; every output 0.
- All outputs registered. A press in cycle N is reflected in the outputs in cycle N+1.
- Valid press: exactly one btn_pulse bit set; its index is the digit.
- Invalid press: two or more bits set. It is counted as a digit that always mismatches.
- btn_pulse = 0: no event.
- LOCKED: a press moves to ENTRY with digit_cnt = 1. A sticky mismatch flag is set if the digit differs from code digit 0.
- ENTRY: each press increments digit_cnt and ORs in the mismatch for digit digit_cnt. Comparison is incremental; no entry buffer is held.
- ENTRY, CODE_LEN-th press with no mismatch: go to UNLOCKED, ok_pulse, fail_cnt cleared.
- ENTRY, CODE_LEN-th press with any mismatch: err_pulse, fail_cnt+1.
  - If fail_cnt reaches MAX_FAIL, go to LOCKOUT.
  - Otherwise go to LOCKED.
  - digit_cnt cleared in both cases.
- CODE_LEN=1: the first press completes the entry directly from LOCKED.
- ENTRY timeout: TIMEOUT_CYC cycles with no press -> LOCKED, digit_cnt 0. Not a failure; fail_cnt unchanged.
- The shared timer reloads on every state change and on every accepted press.
- UNLOCKED:
  - Relocks after UNLOCK_CYC cycles.
  - A press with prog_en=0 relocks immediately; the press is consumed, not used as a digit.
  - prog_en=1 in UNLOCKED -> PROG, digit_cnt 0.
- PROG:
  - Valid presses are written into a shadow code; invalid presses are ignored.
  - After CODE_LEN valid presses, shadow is copied to the code register, ok_pulse, -> UNLOCKED with a fresh UNLOCK_CYC.
  - Abort: prog_en dropping or a TIMEOUT_CYC inter-press gap -> UNLOCKED. Old code kept; shadow discarded.
- LOCKOUT:
  - All presses ignored; lockout=1.
  - After LOCKOUT_CYC cycles -> LOCKED with fail_cnt cleared.
- fail_cnt saturates at 15 and is cleared only by a successful entry, lockout expiry, or reset.
- Press and timer expiry in the same cycle: the press wins and the timer reloads.
- Reset mid-entry or mid-programming: immediate return to the reset state; the code reverts to DEFAULT_CODE.
- Timer width is $clog2 of the largest of the three cycle parameters, plus 1.

Decomposition:
- Package combo_lock_pkg: state enum (5 states, explicit 3-bit encoding matching state_o) and a function for digit width.
- Sub-module lock_timer: loadable down-counter with load, load value, and expired outputs; shared by timeout, lockout and unlock.
- FSM, code register, shadow register and comparison stay in combo_lock_ctrl.

Test Plan:
- Defaults; press btn0,btn1,btn2,btn3 -> unlocked=1 one cycle after the 4th press, ok_pulse for 1 cycle, fail_cnt=0, state_o=2.
- Press btn1,btn1,btn2,btn3 -> err_pulse once, fail_cnt=1, state_o=0. Three such failures -> lockout=1.
  - During lockout, presses have no effect.
  - After LOCKOUT_CYC cycles -> state_o=0, fail_cnt=0.
- btn0,btn1 then idle TIMEOUT_CYC cycles -> state_o=0, digit_cnt=0, fail_cnt unchanged, no err_pulse.
- Unlock, prog_en=1, press btn3,btn3,btn0,btn1 -> ok_pulse.
  - Relock; old code now fails.
  - btn3,btn3,btn0,btn1 unlocks.
- btn_pulse=4'b0011 within an otherwise correct entry -> err_pulse. Unlock then idle UNLOCK_CYC cycles -> unlocked falls.
- Assert rst_n=0 mid-programming after 2 digits -> all outputs 0 immediately; DEFAULT_CODE sequence unlocks after release.
